// File: rtl/integral_pkg.sv
// ============================================================================
// integral_pkg : shared constants and helpers for the integral-image datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package integral_pkg;

    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 8;
    localparam int RD_LAT        = 2;
    localparam int VID_IN_WIDTH  = 320;
    localparam int VID_IN_HEIGHT = 240;

    localparam int REQ_COMPUTE   = 0;
    localparam int REQ_FEATURE   = 1;
    localparam int REQ_HPS       = 2;

    // Explicit wrap so non-power-of-two requester counts never index past n-1.
    function automatic int next_idx(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/integral_mem_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin winner select starting at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);
    import integral_pkg::*;

    always_comb begin : picker_scan
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = (int'(ptr) >= NUM_REQ) ? 0 : int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && valid[j]) begin
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                any      = 1'b1;
            end
            j = next_idx(j, NUM_REQ);
        end
    end

endmodule

`default_nettype wire

// File: rtl/integral_mem_arbiter.sv
// ============================================================================
// integral_mem_arbiter : round-robin/lockable sharing of one integral M10K
// Rev 1.0
// ============================================================================
`default_nettype none

module integral_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = integral_pkg::ADDR_W,
    parameter int DATA_W  = integral_pkg::DATA_W,
    parameter int RD_LAT  = integral_pkg::RD_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic signed [DATA_W-1:0]  rsp_data,
    output logic [ADDR_W-1:0]         mem_read_address,
    output logic [ADDR_W-1:0]         mem_write_address,
    output logic signed [DATA_W-1:0]  mem_write_data,
    output logic                      mem_write,
    input  logic signed [DATA_W-1:0]  mem_read_data
);
    import integral_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         owner;
    logic                     owner_set;
    logic [PTR_W-1:0]         start;
    logic                     releasing;
    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       pick;
    logic [PTR_W-1:0]         pick_idx;
    logic                     pick_any;
    logic                     granted;
    logic                     sel_we;
    logic                     sel_lock;
    logic [ADDR_W-1:0]        sel_addr;
    logic signed [DATA_W-1:0] sel_wdata;
    logic [RD_LAT:0]          tag_valid;
    logic [PTR_W-1:0]         tag_id [RD_LAT+1];
    logic signed [DATA_W-1:0] rsp_hold;

    // A live lock narrows eligibility to the owner; a dropped lock hands the
    // scan to the requester after the owner in that same cycle.
    always_comb begin
        eligible  = req_valid;
        start     = ptr;
        releasing = 1'b0;
        if (owner_set) begin
            if (req_lock[owner]) begin
                eligible = req_valid & (NUM_REQ'(1) << owner);
            end else begin
                releasing = 1'b1;
                start     = PTR_W'(next_idx(int'(owner), NUM_REQ));
            end
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid (eligible),
        .ptr   (start),
        .grant (pick),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign granted   = pick_any & reset;
    assign req_grant = granted ? pick : '0;
    assign sel_we    = req_we[pick_idx];
    assign sel_lock  = req_lock[pick_idx];
    assign sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];

    // Read data arrives unregistered from the M10K; the tag pipeline only says
    // whose it is.
    assign rsp_valid = tag_valid[RD_LAT] ? (NUM_REQ'(1) << tag_id[RD_LAT]) : '0;
    assign rsp_data  = tag_valid[RD_LAT] ? mem_read_data : rsp_hold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr               <= '0;
            owner             <= '0;
            owner_set         <= 1'b0;
            mem_write         <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            mem_read_address  <= '0;
            tag_valid         <= '0;
            rsp_hold          <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (releasing) begin
                owner_set <= 1'b0;
                ptr       <= PTR_W'(next_idx(int'(owner), NUM_REQ));
            end
            if (granted) begin
                if (sel_lock) begin
                    owner_set <= 1'b1;
                    owner     <= pick_idx;
                end else begin
                    owner_set <= 1'b0;
                    ptr       <= PTR_W'(next_idx(int'(pick_idx), NUM_REQ));
                end
            end

            mem_write <= granted & sel_we;
            if (granted && sel_we) begin
                mem_write_address <= sel_addr;
                mem_write_data    <= sel_wdata;
            end
            if (granted && !sel_we) begin
                mem_read_address <= sel_addr;
            end

            tag_valid <= {tag_valid[RD_LAT-1:0], granted & ~sel_we};
            tag_id[0] <= pick_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            if (tag_valid[RD_LAT]) begin
                rsp_hold <= mem_read_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_integral_mem_arbiter.sv
// ============================================================================
// tb_integral_mem_arbiter : scoreboarded bench with behavioural arbiter/memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_integral_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RL = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [N-1:0]             req_valid = '0;
    logic [N-1:0]             req_we = '0;
    logic [N-1:0]             req_lock = '0;
    logic [N*AW-1:0]          req_addr = '0;
    logic [N*DW-1:0]          req_wdata = '0;
    logic [N-1:0]             req_grant;
    logic [N-1:0]             rsp_valid;
    logic signed [DW-1:0]     rsp_data;
    logic [AW-1:0]            mem_read_address;
    logic [AW-1:0]            mem_write_address;
    logic signed [DW-1:0]     mem_write_data;
    logic                     mem_write;
    logic signed [DW-1:0]     mem_read_data;

    integral_mem_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_LAT  (RL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_we            (req_we),
        .req_lock          (req_lock),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_grant         (req_grant),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write         (mem_write),
        .mem_read_data     (mem_read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic signed [DW-1:0] init_val(input int a);
        return DW'(a * 37 + 11);
    endfunction

    // M10K model: write on posedge, read data RL cycles after the address.
    logic signed [DW-1:0] mem [256];
    logic signed [DW-1:0] rd_pipe [RL];
    bit mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            mem[mem_write_address] <= mem_write_data;
        end
        rd_pipe[0] <= mem[mem_read_address];
        for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign mem_read_data = rd_pipe[RL-1];

    // Reference model: arbitration rules plus predicted memory contents.
    typedef struct { int id; int data; int due; } rsp_t;
    rsp_t exp_q[$];
    rsp_t keep_q[$];
    int   ref_mem [256];
    bit   ref_init = 1'b0;
    int   ptr_m = 0;
    int   owner_m = -1;
    logic [N-1:0] gnt_last = '0;

    always @(negedge clk) begin : model
        logic [N-1:0] eg;
        int start, win, a;
        bit clr;
        if (!ref_init) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = int'(init_val(k));
            ref_init = 1'b1;
        end
        eg = '0; win = -1; clr = 1'b0; start = ptr_m;
        if (!reset) begin
            ptr_m = 0;
            owner_m = -1;
            keep_q = {};
            foreach (exp_q[k]) if (exp_q[k].due <= cyc) keep_q.push_back(exp_q[k]);
            exp_q = keep_q;
        end else begin
            if (owner_m >= 0) begin
                if (req_lock[owner_m]) begin
                    if (req_valid[owner_m]) win = owner_m;
                end else begin
                    clr = 1'b1;
                    start = (owner_m + 1) % N;
                end
            end
            if (owner_m < 0 || clr) begin
                for (int k = 0; k < N; k++)
                    if (win < 0 && req_valid[(start + k) % N]) win = (start + k) % N;
            end
            if (clr) begin
                ptr_m = start;
                owner_m = -1;
            end
            if (win >= 0) begin
                eg[win] = 1'b1;
                if (req_lock[win]) owner_m = win;
                else ptr_m = (win + 1) % N;
                a = int'(req_addr[win*AW +: AW]);
                if (req_we[win]) ref_mem[a] = int'($signed(req_wdata[win*DW +: DW]));
                else exp_q.push_back('{win, ref_mem[a], cyc + 1 + RL});
            end
        end
        chk(req_grant == eg, "grant", int'(req_grant), int'(eg));
        gnt_last = req_grant;
    end

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_valid != '0) begin
            chk(exp_q.size() > 0, "rsp_expected", int'(rsp_valid), 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(rsp_valid == (N'(1) << e.id), "rsp_tag", int'(rsp_valid), 1 << e.id);
                chk(int'(rsp_data) == e.data, "rsp_data", int'(rsp_data), e.data);
                chk(cyc == e.due, "rsp_cycle", cyc, e.due);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk(1'b0, "rsp_missing", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input int a, input int d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_lock[i]  = lk;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = DW'(d);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    int rr_exp [4] = '{1, 2, 4, 1};

    initial begin
        @(posedge clk);
        #1;

        // Reset holds everything quiet even with every requester asking.
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, i, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk(gnt_last == '0, "reset_grant", int'(gnt_last), 0);
        end
        chk(rsp_valid == '0, "reset_rsp_valid", int'(rsp_valid), 0);
        chk(mem_write == 1'b0, "reset_mem_write", int'(mem_write), 0);
        chk(rsp_data == '0, "reset_rsp_data", int'(rsp_data), 0);
        chk(mem_read_address == '0, "reset_rd_addr", int'(mem_read_address), 0);

        // Round robin over three reads.
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 5 + i, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk(gnt_last == N'(rr_exp[k]), "rr_grant", int'(gnt_last), rr_exp[k]);
        end
        clear_all();
        idle(5);

        // Locked burst of four writes from req0 while req1 waits.
        set_req(0, 1'b1, 1'b1, 1'b1, 0, 1);
        tick();
        chk(gnt_last == 3'b001, "lock_first", int'(gnt_last), 1);
        set_req(1, 1'b1, 1'b0, 1'b0, 20, 0);
        for (int k = 1; k < 4; k++) begin
            set_req(0, 1'b1, 1'b1, 1'b1, k, k + 1);
            tick();
            chk(gnt_last == 3'b001, "lock_hold", int'(gnt_last), 1);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        chk(gnt_last == 3'b010, "lock_release", int'(gnt_last), 2);
        clear_all();
        idle(2);
        for (int k = 0; k < 4; k++)
            chk(int'(mem[k]) == k + 1, "lock_mem", int'(mem[k]), k + 1);
        idle(3);

        // Read-after-write on the next cycle.
        set_req(0, 1'b1, 1'b1, 1'b0, 12, -7);
        tick();
        chk(gnt_last == 3'b001, "raw_write", int'(gnt_last), 1);
        clear_all();
        set_req(1, 1'b1, 1'b0, 1'b0, 12, 0);
        tick();
        chk(gnt_last == 3'b010, "raw_read", int'(gnt_last), 2);
        clear_all();
        idle(4);
        chk(int'(rsp_data) == -7, "raw_hold", int'(rsp_data), -7);

        // Owner idles with the lock held; others are shut out.
        set_req(2, 1'b1, 1'b0, 1'b1, 3, 0);
        tick();
        chk(gnt_last == 3'b100, "idle_lock", int'(gnt_last), 4);
        set_req(2, 1'b0, 1'b0, 1'b1, 0, 0);
        set_req(0, 1'b1, 1'b0, 1'b0, 1, 0);
        set_req(1, 1'b1, 1'b0, 1'b0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk(gnt_last == '0, "idle_blocked", int'(gnt_last), 0);
        end
        req_lock[2] = 1'b0;
        tick();
        chk(gnt_last == 3'b001, "idle_release", int'(gnt_last), 1);
        set_req(0, 1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        chk(gnt_last == 3'b010, "idle_next", int'(gnt_last), 2);
        clear_all();
        idle(5);

        // Reset lands while a read is in flight.
        set_req(0, 1'b1, 1'b0, 1'b0, 9, 0);
        tick();
        chk(gnt_last == 3'b001, "rstmid_grant", int'(gnt_last), 1);
        clear_all();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk(rsp_valid == '0, "rstmid_rsp", int'(rsp_valid), 0);
            chk(mem_write == 1'b0, "rstmid_write", int'(mem_write), 0);
        end
        reset = 1'b1;
        idle(2);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_last[i] || !req_valid[i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, 1'b1, ($urandom_range(2, 0) == 0), req_lock[i],
                                $urandom_range(15, 0), $urandom_range(255, 0));
                    else
                        req_valid[i] = 1'b0;
                end
                req_lock[i] = ($urandom_range(3, 0) == 0);
            end
            tick();
        end
        clear_all();
        idle(8);
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
